// File: rtl/fp_int_acc.sv
// fp_int_acc: dot-product accumulator fed by the fp_int_mul product stream.
// Each product (sign, exponent bias 15, 15-bit magnitude with 10 fractional
// bits) is aligned to a signed fixed-point value with FRAC_BITS fractional
// bits, registered in stage 1, and added with saturation in stage 2.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_acc_start         pulse: clear accumulator, latch i_len, begin
//   i_len               number of products in the dot product
//   i_start_acc         product valid
//   i_sign_in/i_exp_in/i_mantissa_in   product fields
//   o_acc_out           running / final accumulator value
//   o_done              one-cycle pulse, o_acc_out is final
//   o_busy              high while accumulating
//   o_sat               sticky saturation flag for the current dot product
//
// state | meaning
// IDLE  | waiting for i_acc_start; products are ignored
// ACCUM | accepting products until len adds have committed
module fp_int_acc #(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_acc_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_start_acc,
  input  logic                 i_sign_in,
  input  logic [4:0]           i_exp_in,
  input  logic [14:0]          i_mantissa_in,
  output logic [ACC_WIDTH-1:0] o_acc_out,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_sat
);

  // Widest left shift is exp 30 -> 5 + FRAC_BITS; keep one spare bit so the
  // magnitude compare against the accumulator limits never wraps.
  localparam int MAG_W = 15 + 6 + FRAC_BITS;
  localparam int CW    = ((MAG_W > ACC_WIDTH) ? MAG_W : ACC_WIDTH) + 1;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]        LIM_POS = CW'(ACC_MAX);
  localparam logic [CW-1:0]        LIM_NEG = LIM_POS + CW'(1);
  localparam logic signed [9:0]    SHIFT_OFS = 10'(FRAC_BITS - 25);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_count;
  logic                   r_done;
  logic                   r_sat;
  logic                   r_s1_valid;
  logic [ACC_WIDTH-1:0]   r_s1_val;
  logic                   r_s1_sat;

  logic signed [9:0]      w_shift;
  logic [9:0]             w_shl;
  logic [9:0]             w_shr;
  logic [CW-1:0]          w_mant_ext;
  logic [CW-1:0]          w_mag;
  logic [ACC_WIDTH-1:0]   w_align;
  logic                   w_align_sat;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_sum_ovf;
  logic [ACC_WIDTH-1:0]   w_sum_sat;
  logic                   w_clear;
  logic                   w_commit;
  logic                   w_accept;
  logic                   w_done_nxt;

  // Alignment of the incoming product
  always_comb begin
    w_shift    = $signed({5'b0, i_exp_in}) + SHIFT_OFS;
    w_shl      = w_shift;
    w_shr      = 10'd0 - w_shift;
    w_mant_ext = CW'(i_mantissa_in);
    if (w_shift[9]) begin
      w_mag = w_mant_ext >> w_shr;
    end else begin
      w_mag = w_mant_ext << w_shl;
    end
  end

  always_comb begin
    w_align     = '0;
    w_align_sat = 1'b0;
    if (i_exp_in == 5'd0) begin
      w_align = '0;
    end else if (i_exp_in == 5'd31) begin
      w_align     = i_sign_in ? ACC_MIN : ACC_MAX;
      w_align_sat = 1'b1;
    end else if (i_sign_in) begin
      // A magnitude of exactly 2^(ACC_WIDTH-1) is still representable as min
      if (w_mag > LIM_NEG) begin
        w_align     = ACC_MIN;
        w_align_sat = 1'b1;
      end else begin
        w_align = ACC_WIDTH'(0) - w_mag[ACC_WIDTH-1:0];
      end
    end else begin
      if (w_mag > LIM_POS) begin
        w_align     = ACC_MAX;
        w_align_sat = 1'b1;
      end else begin
        w_align = w_mag[ACC_WIDTH-1:0];
      end
    end
  end

  // Saturating add of stage-1 value into the accumulator
  always_comb begin
    w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {r_s1_val[ACC_WIDTH-1], r_s1_val};
    w_sum_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    if (w_sum_ovf) begin
      w_sum_sat = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      w_sum_sat = w_sum[ACC_WIDTH-1:0];
    end
  end

  // Next-state and control
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_commit    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_acc_start) begin
          w_clear = 1'b1;
          if (i_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (i_acc_start) begin
          w_clear = 1'b1;
          if (i_len == '0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (r_s1_valid) begin
          w_commit = 1'b1;
          if ((r_count + LEN_WIDTH'(1)) == r_len) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Products only enter stage 1 if they will still be in ACCUM to commit;
    // a restart in the same cycle drops the product.
    w_accept = i_start_acc && !i_acc_start && (w_state_nxt == ACCUM);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
      r_s1_sat   <= 1'b0;
    end else begin
      r_done     <= w_done_nxt;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_val <= w_align;
        r_s1_sat <= w_align_sat;
      end
      if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
        r_sat   <= 1'b0;
        r_len   <= i_len;
      end else if (w_commit) begin
        r_acc   <= w_sum_sat;
        r_count <= r_count + LEN_WIDTH'(1);
        r_sat   <= r_sat | r_s1_sat | w_sum_ovf;
      end
    end
  end

  assign o_acc_out = r_acc;
  assign o_done    = r_done;
  assign o_busy    = (r_state == ACCUM);
  assign o_sat     = r_sat;

endmodule

// File: tb/tb_fp_int_acc.sv
module tb_fp_int_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_start;
  logic [7:0]  len;
  logic        start_acc;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [14:0] mant_in;
  logic [31:0] acc_out;
  logic        done;
  logic        busy;
  logic        sat;

  int total = 0;
  int bad   = 0;

  bit ps[32];
  int pe[32];
  int pm[32];

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  fp_int_acc #(
    .ACC_WIDTH(32),
    .FRAC_BITS(8),
    .LEN_WIDTH(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_acc_start  (acc_start),
    .i_len        (len),
    .i_start_acc  (start_acc),
    .i_sign_in    (sign_in),
    .i_exp_in     (exp_in),
    .i_mantissa_in(mant_in),
    .o_acc_out    (acc_out),
    .o_done       (done),
    .o_busy       (busy),
    .o_sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Real-valued product m * 2^(e-25), scaled by 2^8 and truncated toward zero
  function automatic longint align_ref(input bit s, input int e, input int m, output bit f);
    longint mag;
    f = 1'b0;
    if (e == 0) return 0;
    if (e == 31) begin
      f = 1'b1;
      return s ? MINV : MAXV;
    end
    if (e >= 17) mag = longint'(m) * (longint'(1) << (e - 17));
    else         mag = longint'(m) / (longint'(1) << (17 - e));
    if (s) mag = -mag;
    if (mag > MAXV) begin f = 1'b1; mag = MAXV; end
    if (mag < MINV) begin f = 1'b1; mag = MINV; end
    return mag;
  endfunction

  function automatic longint add_ref(input longint a, input longint b, output bit f);
    longint s;
    s = a + b;
    f = 1'b0;
    if (s > MAXV) begin f = 1'b1; s = MAXV; end
    if (s < MINV) begin f = 1'b1; s = MINV; end
    return s;
  endfunction

  task automatic set_prod(input int k, input bit s, input int e, input int m);
    ps[k] = s;
    pe[k] = e;
    pm[k] = m;
  endtask

  // Full dot product: acc_start, n back-to-back products, then done.
  task automatic do_dot(input int n, input string tag);
    longint racc;
    longint a;
    bit     rsat;
    bit     f;
    int     bcnt;
    racc = 0;
    rsat = 1'b0;
    bcnt = 0;
    acc_start = 1'b1;
    len = 8'(n);
    start_acc = 1'b0;
    tick();
    acc_start = 1'b0;
    chk({tag, "_clr_acc"}, $signed(acc_out), 0);
    chk({tag, "_clr_sat"}, sat, 0);
    if (n == 0) begin
      chk({tag, "_len0_done"}, done, 1);
      chk({tag, "_len0_busy"}, busy, 0);
      tick();
      chk({tag, "_len0_done_end"}, done, 0);
      return;
    end
    bcnt += int'(busy);
    for (int k = 0; k < n; k++) begin
      sign_in   = ps[k];
      exp_in    = 5'(pe[k]);
      mant_in   = 15'(pm[k]);
      start_acc = 1'b1;
      tick();
      chk({tag, "_run_acc"}, $signed(acc_out), racc);
      chk({tag, "_run_done"}, done, 0);
      bcnt += int'(busy);
      a = align_ref(ps[k], pe[k], pm[k], f);
      rsat |= f;
      racc = add_ref(racc, a, f);
      rsat |= f;
    end
    start_acc = 1'b0;
    tick();
    chk({tag, "_fin_acc"}, $signed(acc_out), racc);
    chk({tag, "_fin_sat"}, sat, longint'(rsat));
    chk({tag, "_fin_done"}, done, 1);
    chk({tag, "_fin_busy"}, busy, 0);
    chk({tag, "_busy_cycles"}, bcnt, n + 1);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_acc"}, $signed(acc_out), racc);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    acc_start = 1'b0;
    len = '0;
    start_acc = 1'b0;
    sign_in = 1'b0;
    exp_in = '0;
    mant_in = '0;
    tick(); tick(); tick();
    chk("reset_acc", $signed(acc_out), 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sat", sat, 0);
    rst = 1'b0;
    tick();

    // Basic sum
    set_prod(0, 1'b0, 17, 'h400);
    set_prod(1, 1'b1, 16, 'h400);
    set_prod(2, 1'b0, 19, 'h003);
    do_dot(3, "basic");
    chk("basic_const", $signed(acc_out), 'h20C);
    chk("basic_sat", sat, 0);

    // Products in IDLE are ignored
    for (int k = 0; k < 3; k++) begin
      start_acc = 1'b1;
      sign_in = 1'b0;
      exp_in = 5'd25;
      mant_in = 15'h1111;
      tick();
      chk("idle_acc", $signed(acc_out), 'h20C);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
    start_acc = 1'b0;

    // Right-shift truncation and flush-to-zero
    set_prod(0, 1'b0, 10, 'h7FFF);
    set_prod(1, 1'b1, 0, 'h1234);
    do_dot(2, "trunc");
    chk("trunc_const", $signed(acc_out), 255);

    // Saturation
    for (int k = 0; k < 9; k++) set_prod(k, 1'b0, 30, 'h7FFF);
    do_dot(9, "satur");
    chk("satur_const", $signed(acc_out), MAXV);
    chk("satur_flag", sat, 1);
    set_prod(0, 1'b1, 31, int'($urandom_range(0, 32767)));
    do_dot(1, "neg_inf");
    chk("neg_inf_const", $signed(acc_out), MINV);
    chk("neg_inf_sat", sat, 1);

    // len = 0
    do_dot(0, "len0");
    chk("len0_acc", $signed(acc_out), 0);

    // acc_start and start_acc together: that product is dropped
    acc_start = 1'b1; len = 8'd2; start_acc = 1'b1;
    sign_in = 1'b0; exp_in = 5'd17; mant_in = 15'h777;
    tick();
    acc_start = 1'b0;
    chk("same_clr", $signed(acc_out), 0);
    mant_in = 15'h010;
    tick();
    chk("same_s0", $signed(acc_out), 0);
    mant_in = 15'h020;
    tick();
    chk("same_s1", $signed(acc_out), 'h10);
    chk("same_s1_done", done, 0);
    start_acc = 1'b0;
    tick();
    chk("same_fin", $signed(acc_out), 'h30);
    chk("same_done", done, 1);
    tick();
    chk("same_done_end", done, 0);

    // Restart mid-operation discards the in-flight product
    acc_start = 1'b1; len = 8'd4; start_acc = 1'b0;
    tick();
    acc_start = 1'b0;
    start_acc = 1'b1; sign_in = 1'b0; exp_in = 5'd17; mant_in = 15'h050;
    tick();
    mant_in = 15'h060;
    tick();
    chk("restart_pre", $signed(acc_out), 'h50);
    start_acc = 1'b0;
    set_prod(0, 1'b0, 17, 'h100);
    do_dot(1, "restart");
    chk("restart_const", $signed(acc_out), 'h100);

    // Reset mid-accumulation
    acc_start = 1'b1; len = 8'd5;
    tick();
    acc_start = 1'b0;
    start_acc = 1'b1; sign_in = 1'b0; exp_in = 5'd31; mant_in = 15'h1;
    tick();
    exp_in = 5'd20;
    tick();
    chk("rst_pre_sat", sat, 1);
    rst = 1'b1;
    tick();
    chk("rst_acc", $signed(acc_out), 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_acc", $signed(acc_out), 0);
      chk("post_rst_busy", busy, 0);
    end
    start_acc = 1'b0;

    // Random dot products against the reference model
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0)
          set_prod(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 0 : 31,
                   int'($urandom_range(0, 32767)));
        else
          set_prod(k, 1'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
                   int'($urandom_range(0, 32767)));
      end
      do_dot(n, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_int_acc.md
# fp_int_acc

Dot-product accumulator sitting directly downstream of `fp_int_mul`. It consumes the sign/exponent/mantissa product stream qualified by `start_acc` and aligns each product to a signed fixed-point format. It accumulates a programmed number of products with saturation, then presents the dot-product result with a one-cycle `done` pulse.

## Interface
- `ACC_WIDTH`, 32: accumulator/result width, signed two's complement.
- `FRAC_BITS`, 8: fractional bits of `acc_out`.
- `LEN_WIDTH`, 8: width of the product-count field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `acc_start` in 1: one-cycle pulse; clears the accumulator and begins a new dot product.
- `len` in LEN_WIDTH: number of products to accumulate; sampled when `acc_start`=1.
- `start_acc` in 1: product valid, one cycle per product.
- `sign_in` in 1: product sign, 1 = negative.
- `exp_in` in 5: product exponent, bias 15.
- `mantissa_in` in 15: unsigned product magnitude, 10 fractional bits.
- `acc_out` out ACC_WIDTH: running and final accumulator value.
- `done` out 1: one-cycle pulse; `acc_out` is final.
- `busy` out 1: high in ACCUM state.
- `sat` out 1: sticky; saturation occurred in the current dot product.

## Operation
- Product value = (-1)^sign × mantissa × 2^(exp − 25).
- Alignment:
  - shift = exp_in − 25 + FRAC_BITS (= exp_in − 17 at default).
  - If shift ≥ 0, aligned = mantissa << shift.
  - If shift < 0, aligned = mantissa >> −shift, truncating the magnitude.
  - The result is negated if sign=1.
- Special exponents:
  - exp_in=0: contribution is 0 (flush-to-zero).
  - exp_in=31: aligned value forced to +max or −min by sign; sets `sat`.
- Any aligned magnitude not representable in ACC_WIDTH clamps to max/min and sets `sat`.
- Addition saturates: acc + aligned clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Clamping sets `sat`.
- FSM states: IDLE, ACCUM.
  - IDLE -> ACCUM on `acc_start`: acc←0, count←0, `sat`←0, len latched.
  - In ACCUM, each `start_acc` is accepted and count increments when its add commits.
  - When count reaches the latched len, pulse `done` and return to IDLE.
  - `acc_start` with len=0 -> `done` the next cycle, acc=0, stay IDLE.
- `start_acc` in IDLE is ignored, with no state change.
- `acc_start` in ACCUM restarts: acc, count and `sat` cleared, new len latched, in-flight stage-1 product discarded.
- `acc_start` and `start_acc` in the same cycle: `acc_start` wins and the product is dropped.
- Pulses of `start_acc` beyond len cannot occur: the block is in IDLE by then and ignores them.
- Reset values:
  - state IDLE.
  - `acc_out`=0, `done`=0, `busy`=0, `sat`=0.
  - count 0, stage-1 valid 0.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the aligned value and a valid bit at the edge sampling `start_acc`.
  - Stage 2 adds at the next edge.
- Latency: product sampled at edge E is reflected in `acc_out` after edge E+1.
- `done` rises after the edge that commits the len-th add and lasts exactly one cycle. `acc_out` holds the final value until the next `acc_start`.
- `busy` rises after the `acc_start` edge and falls together with `done` rising.
- Throughput: one product per cycle, back-to-back, with no bubbles.
- `rst` takes priority over all inputs. Mid-operation it returns to IDLE, drops pending products, and produces no `done`.

## Test plan
- Basic sum: `acc_start`, len=3, then back-to-back (+,17,0x400), (−,16,0x400), (+,19,0x003).
  - Required: `acc_out`=0x0000020C (1024−512+12) and `done` pulse 2 cycles after the last product.
  - `busy` high for 4 cycles total; `sat`=0.
- Right-shift truncation and flush: len=2 with (+,10,0x7FFF) and (−,0,0x1234).
  - Required: `acc_out`=255, `done`=1 once.
- Saturation: len=9, nine products (+,30,0x7FFF).
  - After 8 products `acc_out`=2147418112; final `acc_out`=0x7FFFFFFF, `sat`=1.
  - Follow with a new `acc_start` -> `sat`=0.
  - len=1 with (−,31,x) -> `acc_out`=0x80000000, `sat`=1.
- Control corner cases:
  - `start_acc` in IDLE leaves `acc_out` unchanged.
  - len=0 -> `done` next cycle with `acc_out`=0.
  - `acc_start` and `start_acc` in the same cycle -> that product is not counted.
- Restart and reset mid-operation:
  - len=4, two products, then `acc_start` with len=1 and (+,17,0x100). Required: `acc_out`=0x100 and a single `done`.
  - `rst` asserted mid-accumulation -> all outputs 0, no `done`.
